bresenham_line: RTL and testbench

- Single-clock line rasteriser using integer Bresenham.
- On a start pulse it latches two 8-bit endpoints, then emits one pixel coordinate per clock on x/y, qualified by plot.
- Raises done when the line is finished.
- Sits between a drawing command source and a framebuffer/pixel writer.

---
 rtl/bresenham_line.sv | 105 ++++++++++
 tb/tb_bresenham_line.sv | 123 ++++++++++++
 2 files changed

// File: rtl/bresenham_line.sv
// bresenham_line: latches two endpoints on start and streams one Bresenham pixel per clock
module bresenham_line #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         plot,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, INIT, DRAW} state_t;
  state_t state_q, state_d;
  logic [W-1:0] xa_q, xa_d, ya_q, ya_d, xb_q, xb_d, yb_q, yb_d, x_q, x_d, y_q, y_d;
  logic signed [W+2:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d, e2, adx, ady;
  logic sx_q, sx_d, sy_q, sy_d, plot_q, plot_d, done_q, done_d, step_x, step_y, at_end;
  always_comb begin
    adx = xa_q < xb_q ? $signed({3'b000, xb_q - xa_q}) : $signed({3'b000, xa_q - xb_q});
    ady = ya_q < yb_q ? $signed({3'b000, yb_q - ya_q}) : $signed({3'b000, ya_q - yb_q});
    e2 = err_q <<< 1;
    step_x = e2 >= dy_q;
    step_y = e2 <= dx_q;
    at_end = x_q == xb_q && y_q == yb_q;
    state_d = state_q;
    xa_d = xa_q;
    ya_d = ya_q;
    xb_d = xb_q;
    yb_d = yb_q;
    x_d = x_q;
    y_d = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    err_d = err_q;
    sx_d = sx_q;
    sy_d = sy_q;
    plot_d = plot_q;
    done_d = done_q;
    case (state_q)
      IDLE: if (start) begin
        xa_d = x0;
        ya_d = y0;
        xb_d = x1;
        yb_d = y1;
        done_d = 1'b0;
        state_d = INIT;
      end
      INIT: begin
        dx_d = adx;
        dy_d = -ady;
        err_d = adx - ady;
        sx_d = !(xa_q < xb_q);
        sy_d = !(ya_q < yb_q);
        x_d = xa_q;
        y_d = ya_q;
        plot_d = 1'b1;
        state_d = DRAW;
      end
      DRAW: if (at_end) begin
        plot_d = 1'b0;
        done_d = 1'b1;
        state_d = IDLE;
      end else begin
        err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
        x_d = step_x ? (sx_q ? x_q - 1'b1 : x_q + 1'b1) : x_q;
        y_d = step_y ? (sy_q ? y_q - 1'b1 : y_q + 1'b1) : y_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      plot_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xa_q <= xa_d;
      ya_q <= ya_d;
      xb_q <= xb_d;
      yb_q <= yb_d;
      x_q <= x_d;
      y_q <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      err_q <= err_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      plot_q <= plot_d;
      done_q <= done_d;
    end
  end
  assign x = x_q;
  assign y = y_q;
  assign plot = plot_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_bresenham_line.sv
// tb_bresenham_line: randomized and directed lines checked against a queue-based Bresenham reference
module tb_bresenham_line;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x, y;
  logic plot, busy, done;
  int total = 0, bad = 0;
  int px[$], py[$];
  bresenham_line #(.W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .x(x), .y(y), .plot(plot), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic void ref_line(input int ax, input int ay, input int bx, input int by);
    int dx = ax < bx ? bx - ax : ax - bx;
    int dy = -(ay < by ? by - ay : ay - by);
    int sx = ax < bx ? 1 : -1;
    int sy = ay < by ? 1 : -1;
    int err = dx + dy;
    int cx = ax, cy = ay, e2;
    px.delete();
    py.delete();
    forever begin
      px.push_back(cx);
      py.push_back(cy);
      if (cx == bx && cy == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endfunction
  task automatic draw(input int ax, input int ay, input int bx, input int by, input bit mid, input bit chain);
    int n;
    ref_line(ax, ay, bx, by);
    n = px.size();
    @(negedge clk);
    x0 = 8'(ax); y0 = 8'(ay); x1 = 8'(bx); y1 = 8'(by);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("init_busy", busy, 1);
    chk("init_plot", plot, 0);
    chk("init_done", done, 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("plot", plot, 1);
      chk("busy", busy, 1);
      chk($sformatf("pix%0d", i), {x, y}, (px[i] << 8) | py[i]);
      if (mid) begin
        x0 = 8'($urandom); y0 = 8'($urandom); x1 = 8'($urandom); y1 = 8'($urandom);
        if (i == n / 2) start = 1'b1;
      end
      if (chain && i == n - 1) begin
        x0 = 8'd7; y0 = 8'd9; x1 = 8'd7; y1 = 8'd9;
        start = 1'b1;
      end
    end
    @(negedge clk);
    chk("end_plot", plot, 0);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    if (!chain) start = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (chain) begin
      chk("chain_busy", busy, 1);
      chk("chain_done", done, 0);
      @(negedge clk);
      chk("chain_pix", {x, y}, (7 << 8) | 9);
      chk("chain_plot", plot, 1);
      @(negedge clk);
      chk("chain_end", done, 1);
    end else begin
      chk("done_level", done, 1);
      chk("idle_busy", busy, 0);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    draw(0, 0, 50, 50, 0, 0);
    draw(10, 20, 10, 20, 0, 0);
    draw(0, 0, 255, 3, 0, 0);
    draw(255, 3, 0, 0, 0, 0);
    draw(200, 10, 5, 250, 0, 0);
    draw(30, 40, 90, 10, 1, 0);
    draw(3, 3, 3, 3, 1, 0);
    draw(100, 100, 120, 130, 0, 1);
    @(negedge clk);
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd100; y1 = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_x", x, 29);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_plot", plot, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("abort_stay", busy, 0);
    draw(5, 7, 60, 2, 0, 0);
    for (int k = 0; k < 20; k++)
      draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
